multicycle_sequencer: RTL and testbench

Control FSM that sequences the MiniRISC datapath over multiple clock cycles instead of one. It decodes the 4-bit opcode and drives ALUSrc, IMMSel, MemWrite, MemRead, ALUOp, WriteReg and MemRegPC. It also drives the instruction-register and PC commit enables, waits on a data-memory ready handshake, and provides run/step/halt control for board debug.

---
 rtl/multicycle_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the MiniRISC datapath: fetch/decode/exec/mem/wb
// sequencing with a memory-ready handshake, a memory timeout trap and run/step/halt debug control.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction register latches (ir_en)
// DECODE | opcode decoded into the control registers
// EXEC   | ALU operation, controls valid
// MEM    | data memory strobe held until mem_ready or timeout
// WB     | register write-back and PC commit, instruction retires
// PAUSE  | single-step hold, waits for step
// HALT   | HALT opcode seen, sticky until rst
// TRAP   | undefined opcode or memory timeout, sticky until rst
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [3:0]         opcode,
    input  logic               mem_ready,
    output logic               ir_en,
    output logic               pc_en,
    output logic               ALUSrc,
    output logic               IMMSel,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [2:0]         ALUOp,
    output logic [1:0]         WriteReg,
    output logic [1:0]         MemRegPC,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PAUSE, S_HALT, S_TRAP
    } state_t;

    state_t state, state_nxt;

    logic       alu_src_q, imm_sel_q, mem_read_q, mem_write_q;
    logic [2:0] alu_op_q;
    logic [1:0] write_reg_q, mem_reg_pc_q;

    logic       dec_alu_src, dec_imm_sel, dec_mem_read, dec_mem_write;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_write_reg, dec_mem_reg_pc;

    logic [7:0] mem_cnt;
    logic       mem_timeout;
    logic       ctl_active;

    assign mem_timeout = (mem_cnt == 8'(MEM_TIMEOUT - 1));

    // Undefined and HALT opcodes decode to all-zero controls.
    always_comb begin
        dec_alu_src    = 1'b0;
        dec_imm_sel    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_op     = 3'b000;
        dec_write_reg  = 2'b00;
        dec_mem_reg_pc = 2'b00;
        case (opcode)
            4'h0: begin
                dec_write_reg  = 2'b01;
                dec_mem_reg_pc = 2'b01;
            end
            4'h1: begin
                dec_alu_src    = 1'b1;
                dec_imm_sel    = 1'b1;
                dec_alu_op     = 3'b001;
                dec_write_reg  = 2'b01;
                dec_mem_reg_pc = 2'b01;
            end
            4'h2: begin
                dec_alu_src    = 1'b1;
                dec_imm_sel    = 1'b1;
                dec_alu_op     = 3'b010;
                dec_write_reg  = 2'b01;
                dec_mem_read   = 1'b1;
            end
            4'h3: begin
                dec_alu_src    = 1'b1;
                dec_imm_sel    = 1'b1;
                dec_alu_op     = 3'b010;
                dec_mem_write  = 1'b1;
            end
            4'h4: dec_alu_op = 3'b011;
            4'h5: dec_alu_op = 3'b100;
            4'h6: begin
                dec_alu_op     = 3'b100;
                dec_write_reg  = 2'b10;
                dec_mem_reg_pc = 2'b10;
            end
            4'h7: dec_alu_op = 3'b100;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == 4'hF)  state_nxt = S_HALT;
                else if (opcode[3])  state_nxt = S_TRAP;
                else                 state_nxt = S_EXEC;
            end
            S_EXEC:   state_nxt = (mem_read_q || mem_write_q) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready)        state_nxt = S_WB;
                else if (mem_timeout) state_nxt = S_TRAP;
            end
            S_WB:     state_nxt = step_mode ? S_PAUSE : S_FETCH;
            S_PAUSE:  if (step) state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src_q    <= 1'b0;
            imm_sel_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_op_q     <= 3'b000;
            write_reg_q  <= 2'b00;
            mem_reg_pc_q <= 2'b00;
            mem_cnt      <= 8'd0;
            instr_count  <= '0;
        end else begin
            if (state == S_DECODE) begin
                alu_src_q    <= dec_alu_src;
                imm_sel_q    <= dec_imm_sel;
                mem_read_q   <= dec_mem_read;
                mem_write_q  <= dec_mem_write;
                alu_op_q     <= dec_alu_op;
                write_reg_q  <= dec_write_reg;
                mem_reg_pc_q <= dec_mem_reg_pc;
            end
            mem_cnt <= (state == S_MEM) ? mem_cnt + 8'd1 : 8'd0;
            if (state == S_WB) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    assign ctl_active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    assign ir_en    = (state == S_FETCH);
    assign pc_en    = (state == S_WB);
    assign ALUSrc   = ctl_active ? alu_src_q : 1'b0;
    assign IMMSel   = ctl_active ? imm_sel_q : 1'b0;
    assign ALUOp    = ctl_active ? alu_op_q : 3'b000;
    assign MemRegPC = ctl_active ? mem_reg_pc_q : 2'b00;
    // Write enable only in WB so each instruction writes the register file once.
    assign WriteReg = (state == S_WB) ? write_reg_q : 2'b00;
    assign MemRead  = (state == S_MEM) && mem_read_q;
    assign MemWrite = (state == S_MEM) && mem_write_q;
    assign busy     = (state == S_FETCH) || (state == S_DECODE) || ctl_active;
    assign halted   = (state == S_HALT);
    assign illegal  = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a decode vector table run back-to-back with a retire
// scoreboard, plus hand sequences for halt, trap, timeout, single-step, reset and wrap.
module tb_multicycle_sequencer;

    localparam int COUNT_W     = 4;
    localparam int MEM_TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0, step_mode = 1'b0, step = 1'b0, mem_ready = 1'b0;
    logic [3:0]         opcode = 4'h0;
    logic               ir_en, pc_en, ALUSrc, IMMSel, MemRead, MemWrite, busy, halted, illegal;
    logic [2:0]         ALUOp;
    logic [1:0]         WriteReg, MemRegPC;
    logic [COUNT_W-1:0] instr_count;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .opcode(opcode), .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en),
        .ALUSrc(ALUSrc), .IMMSel(IMMSel), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUOp(ALUOp), .WriteReg(WriteReg), .MemRegPC(MemRegPC), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        int         wait_n;
        logic       alusrc;
        logic       immsel;
        logic [2:0] aluop;
        logic [1:0] wreg;
        logic [1:0] mrp;
        logic       rd;
        logic       wr;
    } vec_t;

    typedef struct {
        logic       alusrc;
        logic       immsel;
        logic [2:0] aluop;
        logic [1:0] wreg;
        logic [1:0] mrp;
        logic [COUNT_W-1:0] count;
    } sb_t;

    int total = 0;
    int bad   = 0;
    sb_t sb[$];
    logic [COUNT_W-1:0] exp_count = '0;
    vec_t tbl[10];
    vec_t v_r, v_call, v_st;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({ir_en, pc_en, ALUSrc, IMMSel, MemRead, MemWrite, ALUOp, WriteReg,
                    MemRegPC, busy, halted, illegal, instr_count});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; step = 1'b0; step_mode = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        exp_count = '0;
        sb.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_fetch", 32'(ir_en), 32'd1);
    endtask

    // Precondition: the current sampled cycle is FETCH.
    task automatic run_instr(input vec_t v);
        sb_t e, g;
        int cyc = 0, rd = 0, wr = 0, writes = 0, memk = 0;
        bit done = 1'b0;
        g = '{1'b0, 1'b0, 3'b0, 2'b0, 2'b0, '0};
        opcode = v.op;
        mem_ready = 1'b0;
        exp_count = exp_count + 1'b1;
        e = '{v.alusrc, v.immsel, v.aluop, v.wreg, v.mrp, exp_count};
        sb.push_back(e);
        while (!done && cyc < 64) begin
            tick();
            cyc++;
            if (MemRead) rd++;
            if (MemWrite) wr++;
            if (WriteReg != 2'b00) writes++;
            if (MemRead || MemWrite) begin
                mem_ready = (memk >= v.wait_n);
                memk++;
            end else begin
                mem_ready = 1'b0;
            end
            if (pc_en) begin
                done = 1'b1;
                check("wb_cycle", 32'(cyc), (v.rd || v.wr) ? 32'(4 + v.wait_n) : 32'd3);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: got 0 entries want 1");
                end else begin
                    g = sb.pop_front();
                    check("wb_alusrc", 32'(ALUSrc), 32'(g.alusrc));
                    check("wb_immsel", 32'(IMMSel), 32'(g.immsel));
                    check("wb_aluop", 32'(ALUOp), 32'(g.aluop));
                    check("wb_wreg", 32'(WriteReg), 32'(g.wreg));
                    check("wb_mrp", 32'(MemRegPC), 32'(g.mrp));
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL wb_timeout: got no pc_en want pc_en op=%0h", v.op);
        end
        check("rd_cycles", 32'(rd), v.rd ? 32'(v.wait_n + 1) : 32'd0);
        check("wr_cycles", 32'(wr), v.wr ? 32'(v.wait_n + 1) : 32'd0);
        check("reg_writes", 32'(writes), (v.wreg != 2'b00) ? 32'd1 : 32'd0);
        mem_ready = 1'b0;
        tick();
        check("retire_count", 32'(instr_count), 32'(g.count));
        if (step_mode) begin
            check("pause_busy", 32'({busy, ir_en}), 32'd0);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("pause_ignores_start", 32'({busy, ir_en}), 32'd0);
            step = 1'b1;
            tick();
            step = 1'b0;
            check("step_fetch", 32'(ir_en), 32'd1);
        end else begin
            check("next_fetch", 32'(ir_en), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, strobes, rd, pcs;

        tbl[0] = '{4'h0, 0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[1] = '{4'h1, 0, 1'b1, 1'b1, 3'b001, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{4'h2, 0, 1'b1, 1'b1, 3'b010, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[3] = '{4'h3, 0, 1'b1, 1'b1, 3'b010, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[4] = '{4'h4, 0, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{4'h5, 0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[6] = '{4'h6, 0, 1'b0, 1'b0, 3'b100, 2'b10, 2'b10, 1'b0, 1'b0};
        tbl[7] = '{4'h7, 0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[8] = '{4'h2, 3, 1'b1, 1'b1, 3'b010, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[9] = '{4'h3, 2, 1'b1, 1'b1, 3'b010, 2'b00, 2'b00, 1'b0, 1'b1};
        v_r    = tbl[0];
        v_call = tbl[6];
        v_st   = tbl[3];

        // reset overrides a concurrent start
        start = 1'b1;
        tick();
        tick();
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("idle_holds", all_outs(), 32'd0);

        // R-type then HALT; start+step together counts as start
        step = 1'b1;
        do_start();
        step = 1'b0;
        run_instr(v_r);
        opcode = 4'hF;
        tick();
        check("halt_decode", 32'(halted), 32'd0);
        tick();
        check("halted", 32'({halted, busy}), 32'b10);
        pcs = 0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            if (pc_en || ir_en) pcs++;
        end
        check("halt_no_strobes", 32'(pcs), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_count", 32'(instr_count), 32'd1);

        // decode vector table, back to back
        do_reset();
        do_start();
        foreach (tbl[i]) run_instr(tbl[i]);

        // undefined opcode traps from DECODE
        do_reset();
        do_start();
        opcode = 4'hA;
        first = -1;
        strobes = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (illegal && first < 0) first = c;
            if (MemRead || MemWrite || pc_en || ir_en || WriteReg != 2'b00) strobes++;
        end
        check("trap_cycle", 32'(first), 32'd2);
        check("trap_strobes", 32'(strobes), 32'd0);
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        check("trap_sticky", 32'({illegal, busy}), 32'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("trap_cleared", 32'(illegal), 32'd0);

        // memory timeout on LD
        do_reset();
        do_start();
        opcode = 4'h2;
        mem_ready = 1'b0;
        rd = 0;
        pcs = 0;
        for (int c = 0; c < 40 && !illegal; c++) begin
            tick();
            if (MemRead) rd++;
            if (pc_en) pcs++;
        end
        check("timeout_rd", 32'(rd), 32'(MEM_TIMEOUT));
        check("timeout_trap", 32'(illegal), 32'd1);
        check("timeout_no_pc", 32'(pcs), 32'd0);
        check("timeout_count", 32'(instr_count), 32'd0);

        // single-step with three calls
        do_reset();
        step_mode = 1'b1;
        do_start();
        for (int i = 0; i < 3; i++) run_instr(v_call);
        check("step_count", 32'(instr_count), 32'd3);
        step_mode = 1'b0;

        // reset while MEM holds MemWrite
        do_reset();
        do_start();
        run_instr(v_r);
        opcode = v_st.op;
        mem_ready = 1'b0;
        for (int c = 0; c < 10 && !MemWrite; c++) tick();
        tick();
        tick();
        check("st_held", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_mem", all_outs(), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_mem_idle", all_outs(), 32'd0);
        exp_count = '0;
        sb.delete();

        // retired counter wrap
        do_start();
        for (int i = 0; i < 16; i++) run_instr(v_r);
        check("count_wrap", 32'(instr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
